// File: rtl/ssram_stream_reader_if.sv
// ssram_stream_reader_if: SSRAM read port plus outgoing valid/ready stream, grouped for ssram_stream_reader
// Signals: ramAddress/ramReadValid (reader -> SSRAM), ramData (SSRAM -> reader, one clock after ramAddress),
// streamData/streamValid/streamLast (reader -> sink), streamReady (sink -> reader).
// Modports: master = reader side, slave = SSRAM/sink side.
interface ssram_stream_reader_if #(
  parameter int bitwidth = 32,
  parameter int addrWidth = 9
);
  logic [addrWidth-1:0] ramAddress;
  logic ramReadValid;
  logic [bitwidth-1:0] ramData;
  logic [bitwidth-1:0] streamData;
  logic streamValid;
  logic streamReady;
  logic streamLast;
  modport master(
    output ramAddress, ramReadValid, streamData, streamValid, streamLast,
    input ramData, streamReady
  );
  modport slave(
    input ramAddress, ramReadValid, streamData, streamValid, streamLast,
    output ramData, streamReady
  );
endinterface

// File: rtl/ssram_stream_reader.sv
// ssram_stream_reader: reads a block of SSRAM words and streams them out through a 2-entry FIFO
// Ports: clock, resetN (async active-low); start/startAddress/blockSize launch a block (sampled in IDLE only);
// busy is high outside IDLE, done pulses for one cycle when a block completes;
// bus (master modport) carries the SSRAM read port and the valid/ready output stream.
// Option: define SSRAM_STREAM_READER_BYTESWAP_EN to reverse the byte lanes of every streamed word.
module ssram_stream_reader #(
  parameter int bitwidth = 32,
  parameter int nrOfEntries = 512,
  localparam int addrWidth = $clog2(nrOfEntries)
) (
  input  logic clock,
  input  logic resetN,
  input  logic start,
  input  logic [addrWidth-1:0] startAddress,
  input  logic [addrWidth:0] blockSize,
  output logic busy,
  output logic done,
  ssram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic [addrWidth-1:0] address;
  logic [addrWidth:0] issueLeft, beatLeft;
  logic inFlight, wrPtr, rdPtr, pop, issue;
  logic [1:0] count;
  logic [2:0] load;
  logic [bitwidth-1:0] fifo [2];
  logic [bitwidth-1:0] wordIn;
`ifdef SSRAM_STREAM_READER_BYTESWAP_EN
  for (genvar b = 0; b < bitwidth / 8; b++) begin : g_swap
    assign wordIn[8*b +: 8] = bus.ramData[bitwidth-8-8*b +: 8];
  end
`else
  assign wordIn = bus.ramData;
`endif
  assign pop = count != 2'd0 && bus.streamReady;
  // The beat leaving this cycle frees its slot before the word issued now lands, so a
  // continuously ready sink sustains one read per cycle without overflowing the FIFO.
  assign load = 3'(count) + 3'(inFlight) - 3'(pop);
  assign issue = state == READ && load < 3'd2;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bus.ramAddress = address;
  assign bus.ramReadValid = issue;
  assign bus.streamData = fifo[rdPtr];
  assign bus.streamValid = count != 2'd0;
  assign bus.streamLast = bus.streamValid && beatLeft == 1'b1;
  always_ff @(posedge clock) begin
    if (inFlight) fifo[wrPtr] <= wordIn;
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      address <= '0;
      issueLeft <= '0;
      beatLeft <= '0;
      inFlight <= 1'b0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      inFlight <= issue;
      wrPtr <= wrPtr ^ inFlight;
      rdPtr <= rdPtr ^ pop;
      count <= count + {1'b0, inFlight} - {1'b0, pop};
      if (pop) beatLeft <= beatLeft - 1'b1;
      if (issue) begin
        address <= address + 1'b1;
        issueLeft <= issueLeft - 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          address <= startAddress;
          issueLeft <= blockSize;
          beatLeft <= blockSize;
          state <= blockSize == '0 ? DONE : READ;
        end
        READ: if (issue && issueLeft == 1'b1) state <= DRAIN;
        DRAIN: if (pop && beatLeft == 1'b1) state <= DONE;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
